// File: rtl/prco_pipe_ctrl_pkg.sv
// prco_pipe_ctrl_pkg
//   Shared constants for the PRCO pipeline sequencer: state encodings
//   (also read by debug/trace logic) and a small next-state helper.
package prco_pipe_ctrl_pkg;

  localparam logic [2:0] PRCO_PSTATE_IDLE      = 3'd0;
  localparam logic [2:0] PRCO_PSTATE_FETCH     = 3'd1;
  localparam logic [2:0] PRCO_PSTATE_DEC_ISSUE = 3'd2;
  localparam logic [2:0] PRCO_PSTATE_DEC_WAIT  = 3'd3;
  localparam logic [2:0] PRCO_PSTATE_EXEC      = 3'd4;
  localparam logic [2:0] PRCO_PSTATE_MEM       = 3'd5;
  localparam logic [2:0] PRCO_PSTATE_UART      = 3'd6;
  localparam logic [2:0] PRCO_PSTATE_WB        = 3'd7;

  // Where to go once an instruction retires (WB or skipped NOP).
  function automatic logic [2:0] next_after_retire(input logic en);
    logic [2:0] st;
    if (en) begin
      st = PRCO_PSTATE_FETCH;
    end else begin
      st = PRCO_PSTATE_IDLE;
    end
    return st;
  endfunction

endpackage

// File: rtl/prco_pipe_ctrl_wait_timer.sv
// prco_wait_timer
//   8-bit clear/enable counter with a terminal-count flag at MEM_TIMEOUT-1.
//   Ports: i_clk, i_reset_n (async, active-low), i_clr (synchronous clear,
//   dominates), i_en (count enable), o_tc (count == MEM_TIMEOUT-1 while enabled).
module prco_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [7:0] TC_VAL = 8'(MEM_TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: clear wins over enable.
  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = 8'd0;
    end else if (i_en) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_tc = i_en && (count_q == TC_VAL);

endmodule

// File: rtl/prco_pipe_ctrl.sv
// prco_pipe_ctrl
//   Multi-cycle sequencer for the PRCO core: FETCH -> DECODE -> EXEC/MEM/UART
//   -> WB, one instruction at a time. All outputs are registered from the
//   next-state decision so each strobe is visible during its own state.
// Ports:
//   i_clk, i_reset_n            clock, async active-low reset
//   i_en                        run enable (sampled in IDLE, WB and on NOP skip)
//   o_fetch_req / i_fetch_ack   instruction fetch handshake
//   o_dec_ce, i_dec_ce, i_dec_fetch, i_reg_we, i_req_ram, i_req_ram_we,
//   i_new_uart1_data            decoder strobe and result flags
//   o_alu_ce                    ALU execute pulse
//   o_ram_req, o_ram_we, i_ram_ack  RAM access handshake
//   o_uart_start, i_uart_busy   UART1 transmit start
//   o_reg_we, o_pc_inc, o_err   writeback, PC advance, error pulse
//   o_busy, o_state             status
// Configuration: define PRCO_PIPE_PERF_EN to add o_retired/o_stall counters.
module prco_pipe_ctrl
  import prco_pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_en,
  output logic        o_fetch_req,
  input  logic        i_fetch_ack,
  output logic        o_dec_ce,
  input  logic        i_dec_ce,
  input  logic        i_dec_fetch,
  input  logic        i_reg_we,
  input  logic        i_req_ram,
  input  logic        i_req_ram_we,
  input  logic        i_new_uart1_data,
  output logic        o_alu_ce,
  output logic        o_ram_req,
  output logic        o_ram_we,
  input  logic        i_ram_ack,
  output logic        o_uart_start,
  input  logic        i_uart_busy,
  output logic        o_reg_we,
  output logic        o_pc_inc,
  output logic        o_err,
  output logic        o_busy,
`ifdef PRCO_PIPE_PERF_EN
  output logic [15:0] o_retired,
  output logic [15:0] o_stall,
`endif
  output logic [2:0]  o_state
);

  logic [2:0] state_q, state_d;
  logic       reg_we_q, reg_we_d;
  logic       ram_we_q, ram_we_d;
  logic       uart_start_q, uart_start_d;
  logic       reg_wr_q, reg_wr_d;
  logic       pc_skip_d;
  logic       err_q, err_d;
  logic       fetch_req_q, dec_ce_q, alu_ce_q, ram_req_q, ram_wr_q, pc_inc_q, busy_q;
  logic       retire_s;
  logic       stall_s;
  logic       mem_tc_s;

  prco_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_clr    (state_q != PRCO_PSTATE_MEM),
    .i_en     (state_q == PRCO_PSTATE_MEM),
    .o_tc     (mem_tc_s)
  );

  // Sequencer next-state and strobe decisions.
  always_comb begin
    state_d      = state_q;
    reg_we_d     = reg_we_q;
    ram_we_d     = ram_we_q;
    uart_start_d = 1'b0;
    reg_wr_d     = 1'b0;
    pc_skip_d    = 1'b0;
    err_d        = 1'b0;
    retire_s     = 1'b0;
    stall_s      = 1'b0;
    case (state_q)
      PRCO_PSTATE_IDLE: begin
        if (i_en) begin
          state_d = PRCO_PSTATE_FETCH;
        end else begin
          state_d = PRCO_PSTATE_IDLE;
        end
      end
      PRCO_PSTATE_FETCH: begin
        if (i_fetch_ack) begin
          state_d = PRCO_PSTATE_DEC_ISSUE;
        end else begin
          stall_s = 1'b1;
        end
      end
      PRCO_PSTATE_DEC_ISSUE: begin
        state_d = PRCO_PSTATE_DEC_WAIT;
      end
      PRCO_PSTATE_DEC_WAIT: begin
        if (i_dec_fetch) begin
          pc_skip_d = 1'b1;
          retire_s  = 1'b1;
          state_d   = next_after_retire(i_en);
        end else if (i_dec_ce) begin
          reg_we_d = i_reg_we;
          ram_we_d = i_req_ram_we;
          // RAM takes precedence; a simultaneous UART request is dropped.
          if (i_req_ram) begin
            state_d = PRCO_PSTATE_MEM;
          end else if (i_new_uart1_data) begin
            state_d = PRCO_PSTATE_UART;
            // Start is registered, so decide one cycle ahead of the UART cycle it shows in.
            uart_start_d = !i_uart_busy;
          end else begin
            state_d = PRCO_PSTATE_EXEC;
          end
        end else begin
          err_d   = 1'b1;
          state_d = PRCO_PSTATE_IDLE;
        end
      end
      PRCO_PSTATE_EXEC: begin
        reg_wr_d = reg_we_q;
        state_d  = PRCO_PSTATE_WB;
      end
      PRCO_PSTATE_MEM: begin
        if (i_ram_ack) begin
          reg_wr_d = reg_we_q;
          state_d  = PRCO_PSTATE_WB;
        end else if (mem_tc_s) begin
          err_d   = 1'b1;
          state_d = PRCO_PSTATE_WB;
          stall_s = 1'b1;
        end else begin
          stall_s = 1'b1;
        end
      end
      PRCO_PSTATE_UART: begin
        if (uart_start_q) begin
          reg_wr_d = reg_we_q;
          state_d  = PRCO_PSTATE_WB;
        end else begin
          uart_start_d = !i_uart_busy;
          stall_s      = 1'b1;
        end
      end
      PRCO_PSTATE_WB: begin
        retire_s = 1'b1;
        state_d  = next_after_retire(i_en);
      end
      default: begin
        state_d = PRCO_PSTATE_IDLE;
      end
    endcase
  end

  // State, latched decoder flags and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= PRCO_PSTATE_IDLE;
      reg_we_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      uart_start_q <= 1'b0;
      reg_wr_q     <= 1'b0;
      err_q        <= 1'b0;
      fetch_req_q  <= 1'b0;
      dec_ce_q     <= 1'b0;
      alu_ce_q     <= 1'b0;
      ram_req_q    <= 1'b0;
      ram_wr_q     <= 1'b0;
      pc_inc_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      reg_we_q     <= reg_we_d;
      ram_we_q     <= ram_we_d;
      uart_start_q <= uart_start_d;
      reg_wr_q     <= reg_wr_d;
      err_q        <= err_d;
      fetch_req_q  <= (state_d == PRCO_PSTATE_FETCH);
      dec_ce_q     <= (state_d == PRCO_PSTATE_DEC_ISSUE);
      alu_ce_q     <= (state_d == PRCO_PSTATE_EXEC);
      ram_req_q    <= (state_d == PRCO_PSTATE_MEM);
      ram_wr_q     <= (state_d == PRCO_PSTATE_MEM) && ram_we_d;
      pc_inc_q     <= (state_d == PRCO_PSTATE_WB) || pc_skip_d;
      busy_q       <= (state_d != PRCO_PSTATE_IDLE);
    end
  end

  assign o_fetch_req  = fetch_req_q;
  assign o_dec_ce     = dec_ce_q;
  assign o_alu_ce     = alu_ce_q;
  assign o_ram_req    = ram_req_q;
  assign o_ram_we     = ram_wr_q;
  assign o_uart_start = uart_start_q;
  assign o_reg_we     = reg_wr_q;
  assign o_pc_inc     = pc_inc_q;
  assign o_err        = err_q;
  assign o_busy       = busy_q;
  assign o_state      = state_q;

`ifdef PRCO_PIPE_PERF_EN
  logic [15:0] retired_q;
  logic [15:0] stall_q;

  // Retired-instruction and stall-cycle counters, wrapping modulo 2^16.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      retired_q <= 16'd0;
      stall_q   <= 16'd0;
    end else begin
      retired_q <= retired_q + {15'd0, retire_s};
      stall_q   <= stall_q + {15'd0, stall_s};
    end
  end

  assign o_retired = retired_q;
  assign o_stall   = stall_q;
`else
  logic unused_perf_s;
  assign unused_perf_s = retire_s ^ stall_s;
`endif

endmodule

// File: tb/tb_prco_pipe_ctrl.sv
// tb_prco_pipe_ctrl
//   Randomized bench for prco_pipe_ctrl. Each instruction is planned as a
//   cycle-by-cycle timeline (stimulus + expected outputs) from its kind and
//   timing parameters, then played against the DUT with one comparison per cycle.
module tb_prco_pipe_ctrl;

  localparam int MEM_T = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DISS  = 3'd2;
  localparam logic [2:0] ST_DWAIT = 3'd3;
  localparam logic [2:0] ST_EXEC  = 3'd4;
  localparam logic [2:0] ST_MEM   = 3'd5;
  localparam logic [2:0] ST_UART  = 3'd6;
  localparam logic [2:0] ST_WB    = 3'd7;

  localparam int K_ALU = 0;
  localparam int K_NOP = 1;
  localparam int K_MEM = 2;
  localparam int K_UART = 3;
  localparam int K_ERR = 4;

  typedef struct packed {
    logic en, fack, dce, dfetch, rwe, rram, rramwe, uart, rack, ubusy;
  } stim_t;

  typedef struct packed {
    logic fetch_req, dec_ce, alu_ce, ram_req, ram_we, uart_start, reg_we, pc_inc, err, busy;
    logic [2:0] state;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_en = 1'b0, i_fetch_ack = 1'b0, i_dec_ce = 1'b0, i_dec_fetch = 1'b0;
  logic i_reg_we = 1'b0, i_req_ram = 1'b0, i_req_ram_we = 1'b0, i_new_uart1_data = 1'b0;
  logic i_ram_ack = 1'b0, i_uart_busy = 1'b0;
  logic o_fetch_req, o_dec_ce, o_alu_ce, o_ram_req, o_ram_we, o_uart_start;
  logic o_reg_we, o_pc_inc, o_err, o_busy;
  logic [2:0] o_state;
`ifdef PRCO_PIPE_PERF_EN
  logic [15:0] o_retired, o_stall;
`endif

  always #5 clk = ~clk;

  prco_pipe_ctrl #(.MEM_TIMEOUT(MEM_T)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(i_en),
    .o_fetch_req(o_fetch_req), .i_fetch_ack(i_fetch_ack),
    .o_dec_ce(o_dec_ce), .i_dec_ce(i_dec_ce), .i_dec_fetch(i_dec_fetch),
    .i_reg_we(i_reg_we), .i_req_ram(i_req_ram), .i_req_ram_we(i_req_ram_we),
    .i_new_uart1_data(i_new_uart1_data),
    .o_alu_ce(o_alu_ce), .o_ram_req(o_ram_req), .o_ram_we(o_ram_we), .i_ram_ack(i_ram_ack),
    .o_uart_start(o_uart_start), .i_uart_busy(i_uart_busy),
    .o_reg_we(o_reg_we), .o_pc_inc(o_pc_inc), .o_err(o_err), .o_busy(o_busy),
`ifdef PRCO_PIPE_PERF_EN
    .o_retired(o_retired), .o_stall(o_stall),
`endif
    .o_state(o_state)
  );

  exp_t got_s;
  assign got_s = {o_fetch_req, o_dec_ce, o_alu_ce, o_ram_req, o_ram_we, o_uart_start,
                  o_reg_we, o_pc_inc, o_err, o_busy, o_state};

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  bit    carry_pc = 1'b0;
  bit    carry_err = 1'b0;
  bit    resume_en = 1'b1;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%04h exp=%04h", tag, cyc, got, exp);
    end
  endtask

  function automatic stim_t rnd_stim();
    stim_t s;
    s = stim_t'($urandom_range(0, 1023));
    return s;
  endfunction

  function automatic exp_t ex(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.state = st;
    e.busy  = (st != ST_IDLE);
    return e;
  endfunction

  // Queue one cycle; a pulse that lands in the cycle after a NOP/error rides on it.
  task automatic push(input stim_t s, input exp_t e);
    exp_t e2;
    e2 = e;
    e2.pc_inc = e2.pc_inc | carry_pc;
    e2.err    = e2.err | carry_err;
    carry_pc  = 1'b0;
    carry_err = 1'b0;
    stim_q.push_back(s);
    exp_q.push_back(e2);
  endtask

  // Plan one instruction: fw extra fetch waits, mw = cycle of RAM ack (0: never),
  // ub = cycles UART reports busy (from the decode-result cycle), gap = idle cycles after.
  task automatic plan_instr(input int kind, input int fw, input int mw, input int ub,
                            input bit rw, input bit mwe, input int gap);
    stim_t s;
    exp_t  e;
    bit    en_next;
    bit    abort;
    int    m_cycles;
    en_next = (gap == 0);
    abort   = (kind == K_MEM) && (mw == 0);
    for (int i = 1; i <= fw + 1; i++) begin
      s = rnd_stim(); s.fack = (i == fw + 1);
      e = ex(ST_FETCH); e.fetch_req = 1'b1;
      push(s, e);
    end
    s = rnd_stim(); e = ex(ST_DISS); e.dec_ce = 1'b1;
    push(s, e);
    s = rnd_stim(); e = ex(ST_DWAIT);
    s.rwe = rw; s.rramwe = mwe; s.dfetch = 1'b0; s.dce = 1'b1;
    case (kind)
      K_NOP:   begin s.dfetch = 1'b1; s.dce = 1'b0; s.en = en_next; end
      K_ERR:   begin s.dce = 1'b0; end
      K_ALU:   begin s.rram = 1'b0; s.uart = 1'b0; end
      K_MEM:   begin s.rram = 1'b1; end
      K_UART:  begin s.rram = 1'b0; s.uart = 1'b1; s.ubusy = (ub > 0); end
      default: begin end
    endcase
    push(s, e);
    case (kind)
      K_NOP: carry_pc = 1'b1;
      K_ERR: carry_err = 1'b1;
      K_ALU: begin
        s = rnd_stim(); s.en = !en_next;
        e = ex(ST_EXEC); e.alu_ce = 1'b1;
        push(s, e);
      end
      K_MEM: begin
        m_cycles = (mw == 0) ? MEM_T : mw;
        for (int j = 1; j <= m_cycles; j++) begin
          s = rnd_stim(); s.rack = (j == mw);
          e = ex(ST_MEM); e.ram_req = 1'b1; e.ram_we = mwe;
          push(s, e);
        end
      end
      K_UART: begin
        for (int j = 1; j <= ub + 1; j++) begin
          s = rnd_stim();
          if (j <= ub) s.ubusy = (j < ub);
          e = ex(ST_UART); e.uart_start = (j == ub + 1);
          push(s, e);
        end
      end
      default: begin end
    endcase
    if (kind == K_ALU || kind == K_MEM || kind == K_UART) begin
      s = rnd_stim(); s.en = en_next;
      e = ex(ST_WB); e.pc_inc = 1'b1; e.reg_we = rw && !abort; e.err = abort;
      push(s, e);
    end
    for (int g = 1; g <= gap; g++) begin
      s = rnd_stim(); s.en = (g == gap) && resume_en;
      push(s, ex(ST_IDLE));
    end
  endtask

  task automatic drive(input stim_t s);
    i_en = s.en; i_fetch_ack = s.fack; i_dec_ce = s.dce; i_dec_fetch = s.dfetch;
    i_reg_we = s.rwe; i_req_ram = s.rram; i_req_ram_we = s.rramwe;
    i_new_uart1_data = s.uart; i_ram_ack = s.rack; i_uart_busy = s.ubusy;
  endtask

  // Play up to n queued cycles: check outputs at the falling edge, then drive.
  task automatic play(input int n);
    stim_t s;
    exp_t  e;
    for (int k = 0; k < n && exp_q.size() > 0; k++) begin
      @(negedge clk);
      cyc++;
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      check_eq("cycle", 16'(got_s), 16'(e));
      drive(s);
    end
  endtask

  task automatic start_plan();
    stim_t s;
    stim_q.delete(); exp_q.delete();
    carry_pc = 1'b0; carry_err = 1'b0;
    s = rnd_stim(); s.en = 1'b1;
    push(s, ex(ST_IDLE));
  endtask

  initial begin
    int kind, fw, mw, ub, gap;
    drive('0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    start_plan();
    plan_instr(K_ALU,  0, 0, 0, 1'b1, 1'b0, 0);   // ADD
    plan_instr(K_NOP,  0, 0, 0, 1'b0, 1'b0, 0);   // NOP
    plan_instr(K_MEM,  0, 3, 0, 1'b1, 1'b0, 0);   // LW, ack on 3rd MEM cycle
    plan_instr(K_MEM,  0, 0, 0, 1'b1, 1'b1, 0);   // SW, timeout
    plan_instr(K_UART, 0, 0, 4, 1'b0, 1'b0, 0);   // WRITE, busy 4 cycles
    plan_instr(K_MEM,  1, MEM_T, 0, 1'b1, 1'b0, 0); // ack exactly at the timeout cycle
    plan_instr(K_ALU,  0, 0, 0, 1'b1, 1'b0, 2);   // en dropped, then IDLE
    plan_instr(K_ERR,  0, 0, 0, 1'b0, 1'b0, 1);
    plan_instr(K_NOP,  1, 0, 0, 1'b0, 1'b0, 1);
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 4);
      fw   = $urandom_range(0, 2);
      mw   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4);
      ub   = $urandom_range(0, 4);
      gap  = (kind == K_ERR) ? $urandom_range(1, 2)
                             : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      if (t == 39) begin
        resume_en = 1'b0;
        if (gap == 0) gap = 1;
      end
      plan_instr(kind, fw, mw, ub, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), gap);
    end
    play(100000);

    // Reset asserted in the middle of a MEM access.
    resume_en = 1'b1;
    start_plan();
    plan_instr(K_MEM, 0, 0, 0, 1'b1, 1'b1, 0);
    play(6);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async", 16'(got_s), 16'h0000);
    @(posedge clk);
    #1;
    check_eq("rst_hold", 16'(got_s), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    start_plan();
    plan_instr(K_ALU, 0, 0, 0, 1'b1, 1'b0, 0);
    resume_en = 1'b0;
    plan_instr(K_UART, 0, 0, 0, 1'b1, 1'b0, 1);
    play(100000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
